mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised N-channel arbiter that multiplexes requesters onto one single-port on-chip RAM (the 18-bit dpram behind the VTL chip), replacing the fixed-priority combinational mux that selects between downloader, eraser and VTL chip. It adds registered memory outputs, fixed or round-robin priority, a per-access grant handshake and tagged read-data return, so any number of bus masters (downloader, eraser, VTL chip, future DMA) share RAM without glue logic. It sits between the requesters and the dpram in the machine top level.

## Interface
- NUM_CH, 4, number of requester channels (2..8); channel 0 is highest priority in fixed mode
- ADDR_W, 18, address width
- DATA_W, 8, data width
- ROUND_ROBIN, 0, 0 = fixed priority, 1 = round-robin
- RD_LATENCY, 1, RAM read latency in clocks, mem_en cycle to mem_rdata valid (1..3)

- clk  in  1  system clock (F14M domain); all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ena  in  1  arbitration enable; low = no new grants, in-flight reads still complete
- req  in  NUM_CH  per-channel access request
- we  in  NUM_CH  per-channel write (1) / read (0)
- addr  in  NUM_CH*ADDR_W  channel i address at [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_CH*DATA_W  channel i write data at [i*DATA_W +: DATA_W]
- gnt  out  NUM_CH  combinational one-hot accept; access transfers when req[i] & gnt[i]
- rvalid  out  NUM_CH  one-cycle pulse, read data for channel i on rdata
- rdata  out  DATA_W  registered read data, shared by all channels
- busy  out  1  high while mem_en is high or any read is in flight
- mem_addr  out  ADDR_W  registered RAM address
- mem_wdata  out  DATA_W  registered RAM write data
- mem_en  out  1  registered RAM enable
- mem_we  out  1  registered RAM write strobe
- mem_rdata  in  DATA_W  RAM read data

## Operation
- Selection each cycle from current req and registered pointer state: at most one gnt bit high; gnt = 0 when ena = 0 or req = 0.
- Fixed mode: lowest-index requesting channel wins. Round-robin: search starts at rr_ptr, wrapping NUM_CH-1 -> 0; on each accepted access rr_ptr <= winner+1 (mod NUM_CH); rr_ptr unchanged when nothing accepted.
- Accepted access: on that clock edge mem_addr/mem_wdata/mem_we load the winner's addr/wdata/we, mem_en <= 1. No acceptance: mem_en <= 0, mem_we <= 0, mem_addr/mem_wdata hold.
- Requester holds addr/we/wdata stable while req high and gnt low; may issue back-to-back (req held high) -> one access per cycle, 100% throughput for a lone channel.
- Reads: a tag pipeline of depth RD_LATENCY+1 carries {valid, channel id}; entered when a read is accepted. On exit, rdata <= mem_rdata and rvalid[id] pulses for one cycle. Writes create no tag and no rvalid.
- Read data return in issue order; no reordering, no back-pressure on rvalid.
- ena low mid-stream: current-cycle access not accepted; prior accepted reads complete normally.
- busy = mem_en | OR of all tag valid bits.
- Same address read and written by different channels on consecutive cycles: RAM order equals accept order; arbiter adds no forwarding.

## Timing
- Reset (asynchronous assert, synchronous release): mem_en, mem_we, mem_addr, mem_wdata, rdata, rvalid, tag pipeline, rr_ptr all 0; busy 0; gnt follows req/ena combinationally (0 while reset asserted).
- Read accepted in cycle T: mem_en/mem_addr in T+1; mem_rdata sampled at end of T+RD_LATENCY+1; rvalid/rdata in T+RD_LATENCY+2 (RD_LATENCY=1 -> T+3).
- Write accepted in cycle T: mem_we/mem_en high in T+1 only.
- gnt has zero latency from req; mem side one cycle.
- Reset asserted mid-operation: all in-flight reads discarded, no rvalid after release.

## Test plan
- Reset: reset_n=0 with req=4'b1111 -> gnt=0, mem_en=0, rvalid=0, busy=0; release -> gnt=4'b0001 (fixed).
- Single read ch2 addr 18'h08995, RAM holds 8'hA5, RD_LATENCY=1: gnt=4'b0100 in T, mem_addr=18'h08995 mem_en=1 in T+1, rvalid=4'b0100 rdata=8'hA5 in T+3, single pulse.
- Fixed priority contention: req=4'b1011 held 3 cycles -> channel 0 accepted all 3 cycles, channels 1 and 3 starve; drop req[0] -> ch1 accepted next.
- Round-robin: ROUND_ROBIN=1, req=4'b1111 held 8 cycles -> gnt sequence 0,1,2,3,0,1,2,3; mix of writes to 18'h0C000..18'h0C003 lands in that order.
- Back-to-back reads ch1 from 18'h00000..18'h00003 with RD_LATENCY=3 -> mem_en high 4 consecutive cycles, 4 consecutive rvalid[1] pulses in address order, first at T+5.
- ena low for 2 cycles with a read in flight, then reset_n pulse during a second read -> first read returns rvalid, no new gnt while ena low, second read produces no rvalid after reset.

Source files
------------

// File: rtl/mem_arbiter.sv
// N-channel arbiter sharing one single-port RAM: fixed or round-robin selection,
// registered RAM-side outputs and in-order tagged read-data return.
module mem_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 8,
  parameter int ROUND_ROBIN = 0,
  parameter int RD_LATENCY  = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ena,
  input  logic [NUM_CH-1:0]          req,
  input  logic [NUM_CH-1:0]          we,
  input  logic [NUM_CH*ADDR_W-1:0]   addr,
  input  logic [NUM_CH*DATA_W-1:0]   wdata,
  output logic [NUM_CH-1:0]          gnt,
  output logic [NUM_CH-1:0]          rvalid,
  output logic [DATA_W-1:0]          rdata,
  output logic                       busy,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_en,
  output logic                       mem_we,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TAG_DEPTH = RD_LATENCY + 1;

  logic [CH_W-1:0]      rr_ptr;
  logic [CH_W-1:0]      win_id;
  logic [CH_W-1:0]      cand;
  logic                 win_found;
  logic                 win_is_read;
  logic [TAG_DEPTH-1:0] tag_vld;
  logic [CH_W-1:0]      tag_id [TAG_DEPTH];

  function automatic int wrap_idx(input int base, input int offset);
    int s;
    s = base + offset;
    if (s >= NUM_CH) s = s - NUM_CH;
    return s;
  endfunction

  // Search order starts at rr_ptr in round-robin mode, at channel 0 otherwise;
  // the first requesting channel in that order wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    if (reset_n && ena) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ROUND_ROBIN != 0) cand = CH_W'(wrap_idx(int'(rr_ptr), k));
        else                  cand = CH_W'(k);
        if (!win_found && req[cand]) begin
          win_found = 1'b1;
          win_id    = cand;
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (win_found) gnt[win_id] = 1'b1;
  end

  assign win_is_read = win_found & ~we[win_id];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (win_found) begin
      rr_ptr <= (int'(win_id) == NUM_CH - 1) ? '0 : win_id + 1'b1;
    end
  end

  // Address and write data hold when idle so the RAM pins do not toggle needlessly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (win_found) begin
      mem_en    <= 1'b1;
      mem_we    <= we[win_id];
      mem_addr  <= addr[int'(win_id)*ADDR_W +: ADDR_W];
      mem_wdata <= wdata[int'(win_id)*DATA_W +: DATA_W];
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // Stage 0 lines up with mem_en; the last stage lines up with valid mem_rdata.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_id[i] <= '0;
    end else begin
      tag_vld[0] <= win_is_read;
      tag_id[0]  <= win_id;
      for (int i = 1; i < TAG_DEPTH; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= '0;
      if (tag_vld[TAG_DEPTH-1]) begin
        rvalid[tag_id[TAG_DEPTH-1]] <= 1'b1;
        rdata                       <= mem_rdata;
      end
    end
  end

  assign busy = mem_en | (|tag_vld);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fixed-priority, round-robin and 3-cycle-latency
// instances share one stimulus stream, each backed by its own RAM model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ena;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [71:0] addr;
  logic [31:0] wdata;

  logic [3:0]  fix_gnt, fix_rvalid, rr_gnt, rr_rvalid, l3_gnt, l3_rvalid;
  logic [7:0]  fix_rdata, rr_rdata, l3_rdata;
  logic        fix_busy, rr_busy, l3_busy;
  logic [17:0] fix_mem_addr, rr_mem_addr, l3_mem_addr;
  logic [7:0]  fix_mem_wdata, rr_mem_wdata, l3_mem_wdata;
  logic        fix_mem_en, rr_mem_en, l3_mem_en;
  logic        fix_mem_we, rr_mem_we, l3_mem_we;
  logic [7:0]  fix_rd, rr_rd;
  logic [7:0]  l3_pipe [0:2];

  logic [7:0]  ram_fix [0:262143];
  logic [7:0]  ram_rr  [0:262143];
  logic [7:0]  ram_l3  [0:262143];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_CH(4), .ADDR_W(18), .DATA_W(8), .ROUND_ROBIN(0), .RD_LATENCY(1)) u_fix (
    .clk(clk), .reset_n(reset_n), .ena(ena), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(fix_gnt), .rvalid(fix_rvalid), .rdata(fix_rdata), .busy(fix_busy),
    .mem_addr(fix_mem_addr), .mem_wdata(fix_mem_wdata), .mem_en(fix_mem_en),
    .mem_we(fix_mem_we), .mem_rdata(fix_rd));

  mem_arbiter #(.NUM_CH(4), .ADDR_W(18), .DATA_W(8), .ROUND_ROBIN(1), .RD_LATENCY(1)) u_rr (
    .clk(clk), .reset_n(reset_n), .ena(ena), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(rr_gnt), .rvalid(rr_rvalid), .rdata(rr_rdata), .busy(rr_busy),
    .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata), .mem_en(rr_mem_en),
    .mem_we(rr_mem_we), .mem_rdata(rr_rd));

  mem_arbiter #(.NUM_CH(4), .ADDR_W(18), .DATA_W(8), .ROUND_ROBIN(0), .RD_LATENCY(3)) u_l3 (
    .clk(clk), .reset_n(reset_n), .ena(ena), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(l3_gnt), .rvalid(l3_rvalid), .rdata(l3_rdata), .busy(l3_busy),
    .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata), .mem_en(l3_mem_en),
    .mem_we(l3_mem_we), .mem_rdata(l3_pipe[2]));

  // RAM models drive zero on idle cycles so a mistimed sample is visible.
  always @(posedge clk) begin
    if (!reset_n) begin
      ram_fix[18'h08995] <= 8'hA5;
      for (int k = 0; k < 4; k++) ram_l3[k] <= 8'h10 + 8'(k);
      fix_rd <= 8'h00;
      rr_rd  <= 8'h00;
      for (int k = 0; k < 3; k++) l3_pipe[k] <= 8'h00;
    end else begin
      if (fix_mem_en && fix_mem_we) ram_fix[fix_mem_addr] <= fix_mem_wdata;
      if (rr_mem_en && rr_mem_we)   ram_rr[rr_mem_addr]   <= rr_mem_wdata;
      if (l3_mem_en && l3_mem_we)   ram_l3[l3_mem_addr]   <= l3_mem_wdata;
      fix_rd     <= (fix_mem_en && !fix_mem_we) ? ram_fix[fix_mem_addr] : 8'h00;
      rr_rd      <= (rr_mem_en && !rr_mem_we)   ? ram_rr[rr_mem_addr]   : 8'h00;
      l3_pipe[0] <= (l3_mem_en && !l3_mem_we)   ? ram_l3[l3_mem_addr]   : 8'h00;
      l3_pipe[1] <= l3_pipe[0];
      l3_pipe[2] <= l3_pipe[1];
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] r, input logic e);
    req = r;
    ena = e;
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [17:0] a, input logic [7:0] d, input logic w);
    addr[ch*18 +: 18] = a;
    wdata[ch*8 +: 8]  = d;
    we[ch]            = w;
  endtask

  initial begin
    reset_n = 1'b0;
    ena     = 1'b1;
    req     = 4'b1111;
    we      = 4'b0000;
    addr    = '0;
    wdata   = '0;

    // Reset state with every channel requesting.
    tick();
    tick();
    #1;
    check_output("rst_gnt_fix", 32'(fix_gnt), 32'h0);
    check_output("rst_gnt_rr", 32'(rr_gnt), 32'h0);
    check_output("rst_mem_en", 32'(fix_mem_en), 32'h0);
    check_output("rst_rvalid", 32'(fix_rvalid), 32'h0);
    check_output("rst_busy", 32'(fix_busy), 32'h0);
    check_output("rst_mem_addr", 32'(fix_mem_addr), 32'h0);
    reset_n = 1'b1;
    #1;
    check_output("rel_gnt_fix", 32'(fix_gnt), 32'h1);
    check_output("rel_gnt_rr", 32'(rr_gnt), 32'h1);
    apply_stimulus(4'b0000, 1'b1);
    tick();
    check_output("idle_mem_en", 32'(fix_mem_en), 32'h0);

    // Single read on channel 2.
    set_ch(2, 18'h08995, 8'h00, 1'b0);
    apply_stimulus(4'b0100, 1'b1);
    check_output("rd_gnt", 32'(fix_gnt), 32'h4);
    tick();
    apply_stimulus(4'b0000, 1'b1);
    check_output("rd_t1_mem_en", 32'(fix_mem_en), 32'h1);
    check_output("rd_t1_mem_addr", 32'(fix_mem_addr), 32'h08995);
    check_output("rd_t1_mem_we", 32'(fix_mem_we), 32'h0);
    check_output("rd_t1_busy", 32'(fix_busy), 32'h1);
    check_output("rd_t1_rvalid", 32'(fix_rvalid), 32'h0);
    tick();
    check_output("rd_t2_mem_en", 32'(fix_mem_en), 32'h0);
    check_output("rd_t2_busy", 32'(fix_busy), 32'h1);
    check_output("rd_t2_rvalid", 32'(fix_rvalid), 32'h0);
    tick();
    check_output("rd_t3_rvalid", 32'(fix_rvalid), 32'h4);
    check_output("rd_t3_rdata", 32'(fix_rdata), 32'hA5);
    check_output("rd_t3_busy", 32'(fix_busy), 32'h0);
    tick();
    check_output("rd_t4_rvalid", 32'(fix_rvalid), 32'h0);

    // Fixed priority: channel 0 starves 1 and 3 until it drops out.
    set_ch(0, 18'h00100, 8'h50, 1'b1);
    set_ch(1, 18'h00101, 8'h51, 1'b1);
    set_ch(3, 18'h00103, 8'h53, 1'b1);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(4'b1011, 1'b1);
      check_output("fx_gnt_ch0", 32'(fix_gnt), 32'h1);
      tick();
      check_output("fx_mem_addr_ch0", 32'(fix_mem_addr), 32'h00100);
      check_output("fx_mem_wdata_ch0", 32'(fix_mem_wdata), 32'h50);
      check_output("fx_mem_we_ch0", 32'(fix_mem_we), 32'h1);
    end
    apply_stimulus(4'b1010, 1'b1);
    check_output("fx_gnt_ch1", 32'(fix_gnt), 32'h2);
    tick();
    check_output("fx_mem_addr_ch1", 32'(fix_mem_addr), 32'h00101);
    check_output("fx_mem_wdata_ch1", 32'(fix_mem_wdata), 32'h51);
    apply_stimulus(4'b0000, 1'b1);
    tick();
    check_output("fx_idle_mem_en", 32'(fix_mem_en), 32'h0);
    check_output("fx_idle_mem_we", 32'(fix_mem_we), 32'h0);
    check_output("fx_idle_addr_hold", 32'(fix_mem_addr), 32'h00101);

    // Round-robin from a fresh pointer; second lap carries new write data.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) set_ch(i, 18'h0C000 + 18'(i), 8'h30 + 8'(i), 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) for (int i = 0; i < 4; i++) set_ch(i, 18'h0C000 + 18'(i), 8'h40 + 8'(i), 1'b1);
      apply_stimulus(4'b1111, 1'b1);
      check_output("rr_gnt", 32'(rr_gnt), 32'(1 << (k % 4)));
      tick();
      check_output("rr_mem_addr", 32'(rr_mem_addr), 32'h0C000 + 32'(k % 4));
      check_output("rr_mem_wdata", 32'(rr_mem_wdata), ((k < 4) ? 32'h30 : 32'h40) + 32'(k % 4));
    end
    apply_stimulus(4'b0000, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 4; i++)
      check_output("rr_ram_final", 32'(ram_rr[18'h0C000 + 18'(i)]), 32'h40 + 32'(i));

    // Back-to-back reads on channel 1 with a 3-cycle RAM.
    for (int k = 0; k < 4; k++) begin
      set_ch(1, 18'(k), 8'h00, 1'b0);
      apply_stimulus(4'b0010, 1'b1);
      check_output("l3_gnt", 32'(l3_gnt), 32'h2);
      tick();
      check_output("l3_mem_en", 32'(l3_mem_en), 32'h1);
      check_output("l3_mem_addr", 32'(l3_mem_addr), 32'(k));
    end
    apply_stimulus(4'b0000, 1'b1);
    check_output("l3_t4_rvalid", 32'(l3_rvalid), 32'h0);
    tick();
    check_output("l3_t5_mem_en", 32'(l3_mem_en), 32'h0);
    for (int k = 0; k < 4; k++) begin
      check_output("l3_rvalid", 32'(l3_rvalid), 32'h2);
      check_output("l3_rdata", 32'(l3_rdata), 32'h10 + 32'(k));
      if (k == 2) check_output("l3_busy_tail", 32'(l3_busy), 32'h1);
      tick();
    end
    check_output("l3_end_rvalid", 32'(l3_rvalid), 32'h0);
    check_output("l3_end_busy", 32'(l3_busy), 32'h0);

    // ena low with a read in flight, then reset during a second read.
    set_ch(0, 18'h08995, 8'h00, 1'b0);
    set_ch(2, 18'h08995, 8'h00, 1'b0);
    apply_stimulus(4'b0001, 1'b1);
    check_output("en_gnt", 32'(fix_gnt), 32'h1);
    tick();
    apply_stimulus(4'b0001, 1'b0);
    check_output("en_low_gnt_a", 32'(fix_gnt), 32'h0);
    check_output("en_low_mem_en_a", 32'(fix_mem_en), 32'h1);
    tick();
    check_output("en_low_gnt_b", 32'(fix_gnt), 32'h0);
    check_output("en_low_mem_en_b", 32'(fix_mem_en), 32'h0);
    check_output("en_low_busy", 32'(fix_busy), 32'h1);
    tick();
    check_output("en_rvalid", 32'(fix_rvalid), 32'h1);
    check_output("en_rdata", 32'(fix_rdata), 32'hA5);
    check_output("en_no_access", 32'(fix_mem_en), 32'h0);
    apply_stimulus(4'b0100, 1'b1);
    check_output("rs_gnt", 32'(fix_gnt), 32'h4);
    tick();
    check_output("rs_mem_en", 32'(fix_mem_en), 32'h1);
    reset_n = 1'b0;
    #1;
    check_output("rs_async_mem_en", 32'(fix_mem_en), 32'h0);
    check_output("rs_async_busy", 32'(fix_busy), 32'h0);
    check_output("rs_async_gnt", 32'(fix_gnt), 32'h0);
    apply_stimulus(4'b0000, 1'b1);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_output("rs_no_rvalid", 32'(fix_rvalid), 32'h0);
      check_output("rs_busy", 32'(fix_busy), 32'h0);
    end
    check_output("rs_rdata", 32'(fix_rdata), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
